// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand stage.
//   ALU_WIDTH          default datapath width
//   flags_t            latched status flags (carry, zero, optional overflow)
//   FLAG_*_BIT         bit positions of each flag inside flags_t, for microcode
// Configuration macro: ALU_OVERFLOW_FLAG_EN adds the signed overflow flag.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 8;

`ifdef ALU_OVERFLOW_FLAG_EN
    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
    } flags_t;

    localparam int FLAG_OVERFLOW_BIT = 2;
`else
    typedef struct packed {
        logic carry;
        logic zero;
    } flags_t;
`endif

    localparam int FLAG_CARRY_BIT = 1;
    localparam int FLAG_ZERO_BIT  = 0;

endpackage

// File: rtl/alu_operand_stage_load_reg.sv
// ---------------------------------------------------------------------------
// load_reg
// WIDTH-bit register with synchronous active-high reset and load enable.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, clears the register, wins over load_i
//   load_i  capture d_i at the next edge
//   d_i     data to load
//   q_o     registered value
// ---------------------------------------------------------------------------
module load_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Register stage around the external adder/subtractor: A and B operand
// registers, latched flags, and the A / sum drivers onto the shared bus.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   bus_in          shared-bus value (load source for A and B)
//   a_in, b_in      load A / B from bus_in
//   a_out, e_out    drive A / ALU result onto the bus
//   sub_in          subtract select, passed straight through on sub
//   f_in            latch flags
//   alu_out         result returned by the parent's ALU
//   a_q, b_q, sub   operands and mode to the ALU
//   bus_out, bus_oe bus drive value and enable
//   carry_flag, zero_flag  latched flags
//   contention_err  sticky: A and sum drivers enabled together
//   overflow_flag   latched signed overflow (only with ALU_OVERFLOW_FLAG_EN)
// Configuration macro: ALU_OVERFLOW_FLAG_EN.
// ---------------------------------------------------------------------------
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             a_in,
    input  logic             a_out,
    input  logic             b_in,
    input  logic             e_out,
    input  logic             sub_in,
    input  logic             f_in,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             sub,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             contention_err
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    output logic             overflow_flag
`endif
);

    logic [WIDTH-1:0] b_eff;
    logic             carry;
    flags_t           flags_q;
    flags_t           flags_d;
    logic             contention_q;
    logic             contention_d;

    load_reg #(.WIDTH(WIDTH)) u_a_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (a_in),
        .d_i    (bus_in),
        .q_o    (a_q)
    );

    load_reg #(.WIDTH(WIDTH)) u_b_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (b_in),
        .d_i    (bus_in),
        .q_o    (b_q)
    );

    assign sub   = sub_in;
    assign b_eff = b_q ^ {WIDTH{sub_in}};

    // Carry is recomputed locally from the operand registers (subtract is
    // A + ~B + 1, so carry=1 means no borrow); only the top bit is kept.
    assign carry = 1'(({1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_in}) >> WIDTH);

    // Flags sample the pre-edge operands, so a simultaneous load of A/B
    // does not affect the flags latched on the same edge.
    always_comb begin
        flags_d = flags_q;
        if (f_in) begin
            flags_d.carry = carry;
            // Zero comes from the returned result, not the local sum.
            flags_d.zero  = (alu_out == '0);
`ifdef ALU_OVERFLOW_FLAG_EN
            flags_d.overflow = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                               (alu_out[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
    end

    assign contention_d = contention_q | (a_out & e_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= '0;
            contention_q <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            contention_q <= contention_d;
        end
    end

    // Both drivers requested: enable stays high but drive zero, so the bus
    // carries a defined value while the error is flagged.
    always_comb begin
        bus_out = '0;
        bus_oe  = 1'b0;
        unique case ({a_out, e_out})
            2'b10: begin
                bus_out = a_q;
                bus_oe  = 1'b1;
            end
            2'b01: begin
                bus_out = alu_out;
                bus_oe  = 1'b1;
            end
            2'b11: begin
                bus_oe  = 1'b1;
            end
            default: begin
                bus_oe  = 1'b0;
            end
        endcase
    end

    assign carry_flag     = flags_q.carry;
    assign zero_flag      = flags_q.zero;
    assign contention_err = contention_q;
`ifdef ALU_OVERFLOW_FLAG_EN
    assign overflow_flag  = flags_q.overflow;
`endif

endmodule
